snow64_instr_cache: RTL and testbench
=====================================

Name: snow64_instr_cache

Overview:
- Responder end of the IF/ID-to-instruction-cache interface: accepts a fetch request (req, addr) from the IF/ID stage and returns a registered (valid, instr) response.
- Direct-mapped, read-only cache of 256-bit lines.
- On a miss, fetches the full line from the memory arbiter over a req/valid handshake, then serves the re-issued request.

Parameters:
- WIDTH_ADDR, 64, CPU address width.
- WIDTH_INSTR, 32, instruction width.
- WIDTH_LINE, 256, cache line width (8 instructions, 32 bytes).
- NUM_LINES, 16, number of lines; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_if_req  in  1  IF/ID fetch request, re-evaluated every cycle.
- in_if_addr  in  WIDTH_ADDR  byte address of the requested instruction.
- in_flush  in  1  invalidate all lines.
- out_if_valid  out  1  the response in out_if_instr is valid this cycle.
- out_if_instr  out  WIDTH_INSTR  returned instruction.
- out_mem_req  out  1  line-fill request to memory.
- out_mem_addr  out  WIDTH_ADDR  line-aligned fill address (low 5 bits zero).
- in_mem_valid  in  1  fill data present this cycle.
- in_mem_data  in  WIDTH_LINE  fill line; instruction k occupies bits [32k+31:32k].

Behaviour:
- Address split:
  - offset = addr[4:0]; addr[1:0] ignored.
  - word = addr[4:2].
  - index = addr[5+log2(NUM_LINES)-1:5].
  - tag = the remaining upper bits.
- Storage: per-line valid bit, tag and data. Valid bits are cleared by reset and by flush; data and tags are not reset.
- Reset (rst_n=0 at an edge):
  - state=StIdle, all valid bits=0.
  - out_if_valid=0, out_if_instr=0, out_mem_req=0, out_mem_addr=0.
  - Reset in the middle of a miss abandons the fill; a later in_mem_valid is ignored.
- State StIdle:
  - Every edge samples in_if_req and in_if_addr.
  - Hit (req=1, line valid, tag match): out_if_valid<=1 and out_if_instr<=line word, visible the cycle after the request (1-cycle latency).
  - No request: out_if_valid<=0.
  - Miss (req=1, no hit): out_if_valid<=0, capture the line address, out_mem_req<=1, state<=StMiss.
- State StMiss:
  - out_mem_req held at 1 and out_mem_addr held stable until in_mem_valid.
  - out_if_valid=0; incoming requests are ignored. IF/ID keeps re-issuing.
  - On an edge with in_mem_valid=1: write data and tag, set the line valid, out_mem_req<=0, state<=StIdle.
  - The next re-issued request hits. Miss penalty = memory latency + 2 cycles.
- out_if_valid and out_if_instr come from registers only; there is no combinational path from in_if_* to out_if_*. This is required because IF/ID computes its next request from out_if_valid.
- out_if_instr holds its last value while out_if_valid=0.
- Flush:
  - Clears all valid bits at the edge. The hit lookup in the same cycle is evaluated against the pre-flush valid bits.
  - Flush together with fill completion: the filled line is left invalid; state still returns to StIdle.
  - Flush in StMiss does not cancel the outstanding memory request.
- Request address change during StMiss has no effect on the fill in progress.
- in_mem_valid while in StIdle is ignored.

Decomposition:
- Add to the shared package:
  - line, tag, index and word typedefs, plus the offset-width constant.
  - PortIn_Snow64InstrCache_FromPipeStageIfId {req, addr} and PortOut_Snow64InstrCache_ToPipeStageIfId {valid, instr}, bit-compatible with the IF/ID stage's existing instr-cache port structs.
  - Memory-side port structs {req, addr} and {valid, data}.
- One natural sub-module: snow64_instr_cache_line_array, holding tag/valid/data storage with a read port and a write port.

Test Plan:
- Reset then req=1, addr=0x0, memory answers 3 cycles after out_mem_req rises with line words 0x11111111..0x88888888 -> out_mem_req=1 with addr 0x0 one cycle after sampling; valid=0 throughout; the re-issued request returns valid=1, instr=0x11111111 one cycle after re-issue.
- Sequential reqs 0x4, 0x8, 0x1C on the filled line -> valid=1 each following cycle with 0x22222222, 0x33333333, 0x88888888; out_mem_req stays 0.
- Conflict: addr 0x200 (same index 0, different tag) -> miss, out_mem_addr=0x200. After that fill, addr 0x0 misses again.
- in_flush=1 for one cycle, then req 0x0 -> miss with out_mem_req=1. Flush on the same edge as in_mem_valid -> the following request to that line misses.
- Deassert rst_n during StMiss, then pulse in_mem_valid -> no line becomes valid, out_mem_req=0, and a later req to 0x0 misses.
- req=0 for 5 cycles after a hit -> out_if_valid=0 and out_if_instr holds the last value.

Source files
------------

// File: rtl/snow64_instr_cache_pkg.sv
// Shared types for the snow64 instruction cache: address-field widths,
// storage typedefs, FSM state encoding and the IF/ID and memory port structs.
package snow64_instr_cache_pkg;

  localparam int WIDTH_ADDR  = 64;
  localparam int WIDTH_INSTR = 32;
  localparam int WIDTH_LINE  = 256;
  localparam int NUM_LINES   = 16;

  // Byte offset within a line (32 bytes), and the instruction slot inside it.
  localparam int WIDTH_OFFSET = $clog2(WIDTH_LINE / 8);
  localparam int WIDTH_WORD   = $clog2(WIDTH_LINE / WIDTH_INSTR);
  localparam int WIDTH_INDEX  = $clog2(NUM_LINES);
  localparam int WIDTH_TAG    = WIDTH_ADDR - WIDTH_OFFSET - WIDTH_INDEX;

  typedef logic [WIDTH_LINE-1:0]  line_t;
  typedef logic [WIDTH_TAG-1:0]   tag_t;
  typedef logic [WIDTH_INDEX-1:0] index_t;
  typedef logic [WIDTH_WORD-1:0]  word_t;

  // Cache controller state; StMiss waits for a line fill from memory.
  typedef enum logic {
    StIdle = 1'b0,
    StMiss = 1'b1
  } state_t;

  // Bit layout matches the IF/ID stage's existing instr-cache port structs.
  typedef struct packed {
    logic                  req;
    logic [WIDTH_ADDR-1:0] addr;
  } PortIn_Snow64InstrCache_FromPipeStageIfId;

  typedef struct packed {
    logic                   valid;
    logic [WIDTH_INSTR-1:0] instr;
  } PortOut_Snow64InstrCache_ToPipeStageIfId;

  // Memory-arbiter side of the line fill.
  typedef struct packed {
    logic                  req;
    logic [WIDTH_ADDR-1:0] addr;
  } PortOut_Snow64InstrCache_ToMemArbiter;

  typedef struct packed {
    logic  valid;
    line_t data;
  } PortIn_Snow64InstrCache_FromMemArbiter;

endpackage

// File: rtl/snow64_instr_cache_line_array.sv
// Direct-mapped line storage: per-line valid bit, tag and data with one
// combinational read port and one synchronous write port. Only the valid
// bits are reset/flushed; tags and data keep whatever they last held.
module snow64_instr_cache_line_array #(
  parameter int WIDTH_TAG   = 55,
  parameter int WIDTH_INDEX = 4,
  parameter int WIDTH_LINE  = 256,
  parameter int NUM_LINES   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH_INDEX-1:0] rd_index,
  output logic                   rd_valid,
  output logic [WIDTH_TAG-1:0]   rd_tag,
  output logic [WIDTH_LINE-1:0]  rd_data,
  input  logic                   wr_en,
  input  logic [WIDTH_INDEX-1:0] wr_index,
  input  logic [WIDTH_TAG-1:0]   wr_tag,
  input  logic [WIDTH_LINE-1:0]  wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [WIDTH_TAG-1:0]  tag_q  [NUM_LINES];
  logic [WIDTH_LINE-1:0] data_q [NUM_LINES];

  // Valid bits: flush wins over a same-edge fill, so that line stays invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload, written on fill completion only.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/snow64_instr_cache.sv
// Direct-mapped, read-only instruction cache answering the IF/ID stage.
// Handshake: IF/ID holds in_if_req/in_if_addr and the cache samples them at
// every edge in StIdle; a registered out_if_valid=1 the following cycle marks
// out_if_instr as the answer. On a miss out_mem_req stays high with a stable
// line-aligned out_mem_addr until an edge with in_mem_valid=1 delivers the line.
module snow64_instr_cache
  import snow64_instr_cache_pkg::*;
#(
  parameter int WIDTH_ADDR  = 64,
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_LINE  = 256,
  parameter int NUM_LINES   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_if_req,
  input  logic [WIDTH_ADDR-1:0]  in_if_addr,
  input  logic                   in_flush,
  output logic                   out_if_valid,
  output logic [WIDTH_INSTR-1:0] out_if_instr,
  output logic                   out_mem_req,
  output logic [WIDTH_ADDR-1:0]  out_mem_addr,
  input  logic                   in_mem_valid,
  input  logic [WIDTH_LINE-1:0]  in_mem_data
);

  localparam int OFF_W  = $clog2(WIDTH_LINE / 8);
  localparam int WORD_W = $clog2(WIDTH_LINE / WIDTH_INSTR);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WIDTH_ADDR - OFF_W - IDX_W;
  localparam int BYTE_W = OFF_W - WORD_W;

  state_t state;

  logic [IDX_W-1:0]       req_index;
  logic [TAG_W-1:0]       req_tag;
  logic [WORD_W-1:0]      req_word;
  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [WIDTH_LINE-1:0]  rd_data;
  logic                   hit;
  logic [WIDTH_INSTR-1:0] hit_instr;
  logic                   fill_done;
  logic                   unused_byte_bits;

  // Address split of the incoming request.
  assign req_word  = in_if_addr[OFF_W-1:BYTE_W];
  assign req_index = in_if_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag   = in_if_addr[WIDTH_ADDR-1:OFF_W+IDX_W];
  // Byte-within-instruction bits carry no meaning for a fetch.
  assign unused_byte_bits = ^in_if_addr[BYTE_W-1:0];

  assign hit       = in_if_req && rd_valid && (rd_tag == req_tag);
  assign fill_done = (state == StMiss) && in_mem_valid;

  // Word select out of the looked-up line.
  always_comb begin
    hit_instr = rd_data[req_word*WIDTH_INSTR +: WIDTH_INSTR];
  end

  snow64_instr_cache_line_array #(
    .WIDTH_TAG  (TAG_W),
    .WIDTH_INDEX(IDX_W),
    .WIDTH_LINE (WIDTH_LINE),
    .NUM_LINES  (NUM_LINES)
  ) u_line_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (in_flush),
    .rd_index(req_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_done),
    .wr_index(out_mem_addr[OFF_W+IDX_W-1:OFF_W]),
    .wr_tag  (out_mem_addr[WIDTH_ADDR-1:OFF_W+IDX_W]),
    .wr_data (in_mem_data)
  );

  // Controller FSM with all IF/ID and memory outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StIdle;
      out_if_valid <= 1'b0;
      out_if_instr <= '0;
      out_mem_req  <= 1'b0;
      out_mem_addr <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (hit) begin
            out_if_valid <= 1'b1;
            out_if_instr <= hit_instr;
          end else if (in_if_req) begin
            out_if_valid <= 1'b0;
            out_mem_req  <= 1'b1;
            out_mem_addr <= {in_if_addr[WIDTH_ADDR-1:OFF_W], {OFF_W{1'b0}}};
            state        <= StMiss;
          end else begin
            out_if_valid <= 1'b0;
          end
        end
        StMiss: begin
          out_if_valid <= 1'b0;
          if (in_mem_valid) begin
            out_mem_req <= 1'b0;
            state       <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_instr_cache.sv
// Directed bench for snow64_instr_cache: inputs change 1 time unit after a
// rising edge, outputs are checked 1 time unit after the following edge.
module tb_snow64_instr_cache;

  logic         clk;
  logic         rst_n;
  logic         in_if_req;
  logic [63:0]  in_if_addr;
  logic         in_flush;
  logic         out_if_valid;
  logic [31:0]  out_if_instr;
  logic         out_mem_req;
  logic [63:0]  out_mem_addr;
  logic         in_mem_valid;
  logic [255:0] in_mem_data;

  int n_checks;
  int n_fail;

  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] line_c;

  snow64_instr_cache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if_req   (in_if_req),
    .in_if_addr  (in_if_addr),
    .in_flush    (in_flush),
    .out_if_valid(out_if_valid),
    .out_if_instr(out_if_instr),
    .out_mem_req (out_mem_req),
    .out_mem_addr(out_mem_addr),
    .in_mem_valid(in_mem_valid),
    .in_mem_data (in_mem_data)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] inc);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + inc * k;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_if_req = 1'b0; in_if_addr = '0; in_flush = 1'b0;
    in_mem_valid = 1'b0; in_mem_data = '0;
    step(); step();
    n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_if_valid); end
    n_checks++; if (out_if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", out_if_instr); end
    n_checks++; if (out_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", out_mem_req); end
    n_checks++; if (out_mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", out_mem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_miss_fill();
    in_if_req = 1'b1; in_if_addr = 64'h0;
    step();
    n_checks++; if (out_mem_req !== 1'b1) begin n_fail++; $display("FAIL miss_mem_req got=%b exp=1", out_mem_req); end
    n_checks++; if (out_mem_addr !== 64'h0) begin n_fail++; $display("FAIL miss_mem_addr got=%h exp=0", out_mem_addr); end
    n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid got=%b exp=0", out_if_valid); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (out_mem_req !== 1'b1) begin n_fail++; $display("FAIL miss_wait_req[%0d] got=%b exp=1", i, out_mem_req); end
      n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL miss_wait_valid[%0d] got=%b exp=0", i, out_if_valid); end
    end
    in_mem_valid = 1'b1; in_mem_data = line_a;
    step();
    in_mem_valid = 1'b0;
    n_checks++; if (out_mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_mem_req got=%b exp=0", out_mem_req); end
    n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid got=%b exp=0", out_if_valid); end
    step();
    n_checks++; if (out_if_valid !== 1'b1) begin n_fail++; $display("FAIL reissue_valid got=%b exp=1", out_if_valid); end
    n_checks++; if (out_if_instr !== 32'h11111111) begin n_fail++; $display("FAIL reissue_instr got=%h exp=11111111", out_if_instr); end
  endtask

  task automatic test_sequential();
    logic [63:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{64'h4, 64'h8, 64'h1C};
    exps  = '{32'h22222222, 32'h33333333, 32'h88888888};
    for (int i = 0; i < 3; i++) begin
      in_if_req = 1'b1; in_if_addr = addrs[i];
      step();
      n_checks++; if (out_if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, out_if_valid); end
      n_checks++; if (out_if_instr !== exps[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, out_if_instr, exps[i]); end
      n_checks++; if (out_mem_req !== 1'b0) begin n_fail++; $display("FAIL seq_mem_req[%0d] got=%b exp=0", i, out_mem_req); end
    end
  endtask

  task automatic test_conflict();
    in_if_req = 1'b1; in_if_addr = 64'h200;
    step();
    n_checks++; if (out_mem_req !== 1'b1) begin n_fail++; $display("FAIL conf_mem_req got=%b exp=1", out_mem_req); end
    n_checks++; if (out_mem_addr !== 64'h200) begin n_fail++; $display("FAIL conf_mem_addr got=%h exp=200", out_mem_addr); end
    // Address wanders while the fill is outstanding.
    in_if_addr = 64'h440;
    step();
    n_checks++; if (out_mem_addr !== 64'h200) begin n_fail++; $display("FAIL conf_addr_stable got=%h exp=200", out_mem_addr); end
    in_if_addr = 64'h204; in_mem_valid = 1'b1; in_mem_data = line_b;
    step();
    in_mem_valid = 1'b0;
    step();
    n_checks++; if (out_if_valid !== 1'b1) begin n_fail++; $display("FAIL conf_hit_valid got=%b exp=1", out_if_valid); end
    n_checks++; if (out_if_instr !== 32'hB0000001) begin n_fail++; $display("FAIL conf_hit_instr got=%h exp=b0000001", out_if_instr); end
    in_if_addr = 64'h0;
    step();
    n_checks++; if (out_mem_req !== 1'b1) begin n_fail++; $display("FAIL conf_evict_req got=%b exp=1", out_mem_req); end
    n_checks++; if (out_mem_addr !== 64'h0) begin n_fail++; $display("FAIL conf_evict_addr got=%h exp=0", out_mem_addr); end
    n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL conf_evict_valid got=%b exp=0", out_if_valid); end
    in_mem_valid = 1'b1; in_mem_data = line_a;
    step();
    in_mem_valid = 1'b0;
    step();
    n_checks++; if (out_if_instr !== 32'h11111111 || out_if_valid !== 1'b1) begin n_fail++; $display("FAIL conf_refill got=%b/%h exp=1/11111111", out_if_valid, out_if_instr); end
  endtask

  task automatic test_flush();
    // Lookup on the flush edge still sees the old valid bits.
    in_if_req = 1'b1; in_if_addr = 64'h4; in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    n_checks++; if (out_if_valid !== 1'b1 || out_if_instr !== 32'h22222222) begin n_fail++; $display("FAIL flush_same_edge got=%b/%h exp=1/22222222", out_if_valid, out_if_instr); end
    in_if_addr = 64'h0;
    step();
    n_checks++; if (out_mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_miss_req got=%b exp=1", out_mem_req); end
    n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_miss_valid got=%b exp=0", out_if_valid); end
    // Flush together with fill completion leaves the line invalid.
    in_mem_valid = 1'b1; in_mem_data = line_a; in_flush = 1'b1;
    step();
    in_mem_valid = 1'b0; in_flush = 1'b0;
    n_checks++; if (out_mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_fill_req got=%b exp=0", out_mem_req); end
    step();
    n_checks++; if (out_mem_req !== 1'b1 || out_if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fill_remiss got=%b/%b exp=1/0", out_mem_req, out_if_valid); end
    in_mem_valid = 1'b1; in_mem_data = line_a;
    step();
    in_mem_valid = 1'b0;
    step();
    n_checks++; if (out_if_valid !== 1'b1 || out_if_instr !== 32'h11111111) begin n_fail++; $display("FAIL flush_refill got=%b/%h exp=1/11111111", out_if_valid, out_if_instr); end
  endtask

  task automatic test_reset_during_miss();
    in_if_req = 1'b1; in_if_addr = 64'h400;
    step();
    n_checks++; if (out_mem_req !== 1'b1 || out_mem_addr !== 64'h400) begin n_fail++; $display("FAIL rstmiss_req got=%b/%h exp=1/400", out_mem_req, out_mem_addr); end
    rst_n = 1'b0; in_if_req = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (out_mem_req !== 1'b0 || out_mem_addr !== 64'h0) begin n_fail++; $display("FAIL rstmiss_clear got=%b/%h exp=0/0", out_mem_req, out_mem_addr); end
    in_mem_valid = 1'b1; in_mem_data = line_c;
    step();
    in_mem_valid = 1'b0;
    n_checks++; if (out_mem_req !== 1'b0 || out_if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmiss_late_data got=%b/%b exp=0/0", out_mem_req, out_if_valid); end
    in_if_req = 1'b1; in_if_addr = 64'h0;
    step();
    n_checks++; if (out_mem_req !== 1'b1 || out_if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmiss_line0_miss got=%b/%b exp=1/0", out_mem_req, out_if_valid); end
    in_mem_valid = 1'b1; in_mem_data = line_a;
    step();
    in_mem_valid = 1'b0;
    step();
    n_checks++; if (out_if_valid !== 1'b1 || out_if_instr !== 32'h11111111) begin n_fail++; $display("FAIL rstmiss_refill got=%b/%h exp=1/11111111", out_if_valid, out_if_instr); end
  endtask

  task automatic test_idle_hold();
    in_if_req = 1'b1; in_if_addr = 64'h8;
    step();
    n_checks++; if (out_if_valid !== 1'b1 || out_if_instr !== 32'h33333333) begin n_fail++; $display("FAIL hold_hit got=%b/%h exp=1/33333333", out_if_valid, out_if_instr); end
    in_if_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Stray fill data while idle must not land anywhere.
      in_mem_valid = (i == 1); in_mem_data = {256{1'b1}};
      step();
      n_checks++; if (out_if_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b exp=0", i, out_if_valid); end
      n_checks++; if (out_if_instr !== 32'h33333333) begin n_fail++; $display("FAIL hold_instr[%0d] got=%h exp=33333333", i, out_if_instr); end
    end
    in_mem_valid = 1'b0;
    in_if_req = 1'b1; in_if_addr = 64'h8;
    step();
    n_checks++; if (out_if_valid !== 1'b1 || out_if_instr !== 32'h33333333 || out_mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_mem_ignored got=%b/%h/%b exp=1/33333333/0", out_if_valid, out_if_instr, out_mem_req); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    line_a = make_line(32'h11111111, 32'h11111111);
    line_b = make_line(32'hB0000000, 32'h1);
    line_c = make_line(32'hC0000000, 32'h1);
    test_reset();
    test_miss_fill();
    test_sequential();
    test_conflict();
    test_flush();
    test_reset_during_miss();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
